// File: rtl/inv_pipe_pkg.sv
// Shared definitions for the inverting valid/ready pipeline.
// Default geometry and the per-stage beat record.
package inv_pipe_pkg;

    localparam int unsigned INV_PIPE_WIDTH_DEF = 8;
    localparam int unsigned INV_PIPE_DEPTH_DEF = 4;

    // One pipeline stage at default width: valid flag, stored data, carried parity.
    typedef struct packed {
        logic                          valid;
        logic [INV_PIPE_WIDTH_DEF-1:0] data;
        logic                          parity;
    } stage_t;

endpackage

// File: rtl/cmos_inv_bank.sv
// Bank of WIDTH switch-level CMOS inverters; purely combinational.
// This is the only switch-level code in the pipeline.
module cmos_inv_bank #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    output wire  [WIDTH-1:0] y
);

    supply1 vdd;
    supply0 gnd;

    // Each bit: pmos pulls y high when a=0, nmos pulls y low when a=1.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pmos p (y[i], vdd, a[i]);
        nmos n (y[i], gnd, a[i]);
    end

endmodule

// File: rtl/inv_pipeline.sv
// DEPTH-stage valid/ready pipeline with optional per-beat inversion at entry
// and an occupancy counter. Optional feature macro: INV_PIPE_PARITY_EN adds
// out_parity, the even parity of the stored entry data carried with each beat.
module inv_pipeline
    import inv_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = INV_PIPE_WIDTH_DEF,
    parameter int unsigned DEPTH = INV_PIPE_DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       invert,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef INV_PIPE_PARITY_EN
    ,
    output logic                       out_parity
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] load;
    logic [WIDTH-1:0] inv_data;
    logic [WIDTH-1:0] entry_data;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             pop;

    cmos_inv_bank #(
        .WIDTH(WIDTH)
    ) u_inv_bank (
        .a(in_data),
        .y(inv_data)
    );

    // Stage k may take a new value when the consumer pops or any stage at or
    // after k is empty; this flattens the advance chain and lets bubbles collapse.
    always_comb begin
        load = '0;
        for (int k = 0; k < DEPTH; k++) begin
            load[k] = out_ready;
            for (int j = k; j < DEPTH; j++) begin
                if (!valid_q[j]) begin
                    load[k] = 1'b1;
                end
            end
        end
    end

    // Handshake, entry transform and output taps.
    always_comb begin
        in_ready   = !rst && load[0];
        accept     = in_valid && in_ready;
        pop        = valid_q[DEPTH-1] && out_ready;
        entry_data = invert ? inv_data : in_data;
        out_valid  = valid_q[DEPTH-1];
        out_data   = data_q[DEPTH-1];
        occupancy  = cnt_q;
    end

    // Stage registers; data only moves with a valid beat so an emptied
    // last stage keeps showing its most recent value.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            if (load[0]) begin
                valid_q[0] <= in_valid;
                if (in_valid) begin
                    data_q[0] <= entry_data;
                end
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (load[k]) begin
                    valid_q[k] <= valid_q[k-1];
                    if (valid_q[k-1]) begin
                        data_q[k] <= data_q[k-1];
                    end
                end
            end
        end
    end

    // Occupancy: +1 on accept, -1 on pop, unchanged when both or neither.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

`ifdef INV_PIPE_PARITY_EN
    logic [DEPTH-1:0] parity_q;

    // Parity travels in lock-step with the stage data.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= '0;
        end else begin
            if (load[0] && in_valid) begin
                parity_q[0] <= ^entry_data;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (load[k] && valid_q[k-1]) begin
                    parity_q[k] <= parity_q[k-1];
                end
            end
        end
    end

    assign out_parity = parity_q[DEPTH-1];
`endif

endmodule
